// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment scan decoder: active-low
// gfedcba patterns, the blank/invalid code and the capture FSM encoding.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic {
        WAIT = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] value;
        logic       blank;
        logic       invalid;
    } seg_dec_t;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display-bus snoop interface: active-low anode/segment pins in, decoded
// per-digit snapshot and frame/scan-error pulses out.
interface seg_scan_decoder_if #(
    parameter int DIGITS = 4
) ();

    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;
    logic [4*DIGITS-1:0] digits_bcd;
    logic [DIGITS-1:0]   dp_lit;
    logic [DIGITS-1:0]   blank;
    logic [DIGITS-1:0]   invalid;
    logic                frame_valid;
    logic                scan_err;

    modport master (
        output an, seg,
        input  digits_bcd, dp_lit, blank, invalid, frame_valid, scan_err
    );

    modport slave (
        input  an, seg,
        output digits_bcd, dp_lit, blank, invalid, frame_valid, scan_err
    );

endinterface

// File: rtl/seg_to_bcd.sv
// Combinational active-low gfedcba -> {value, blank, invalid} decoder.
// Hex letters A-F decode only when SEG_DECODE_HEX_EN is defined.
module seg_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] seg_n,
    output seg_dec_t   dec
);

    always_comb begin
        dec.value   = BLANK_CODE;
        dec.blank   = 1'b0;
        dec.invalid = 1'b0;
        case (seg_n)
            SEG_0:     dec.value = 4'h0;
            SEG_1:     dec.value = 4'h1;
            SEG_2:     dec.value = 4'h2;
            SEG_3:     dec.value = 4'h3;
            SEG_4:     dec.value = 4'h4;
            SEG_5:     dec.value = 4'h5;
            SEG_6:     dec.value = 4'h6;
            SEG_7:     dec.value = 4'h7;
            SEG_8:     dec.value = 4'h8;
            SEG_9:     dec.value = 4'h9;
`ifdef SEG_DECODE_HEX_EN
            SEG_HEX_A: dec.value = 4'hA;
            SEG_HEX_B: dec.value = 4'hB;
            SEG_HEX_C: dec.value = 4'hC;
            SEG_HEX_D: dec.value = 4'hD;
            SEG_HEX_E: dec.value = 4'hE;
            SEG_HEX_F: dec.value = 4'hF;
`endif
            SEG_BLANK: dec.blank = 1'b1;
            default:   dec.invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus, debounces each scan step and
// publishes a per-frame digit snapshot. Hex decode: define SEG_DECODE_HEX_EN.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    seg_scan_decoder_if.slave   bus
);

    localparam int SW = DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SW-1:0] sync1_q, sync1_d;
    logic [SW-1:0] sync2_q, sync2_d;
    logic [SW-1:0] prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_e        state_q, state_d;

    logic [DIGITS-1:0][3:0] digits_q, digits_d;
    logic [DIGITS-1:0]      dp_q, dp_d;
    logic [DIGITS-1:0]      blank_q, blank_d;
    logic [DIGITS-1:0]      invalid_q, invalid_d;
    logic [DIGITS-1:0]      seen_q, seen_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   scan_err_q, scan_err_d;

    logic [DIGITS-1:0] an_low;
    logic [7:0]        seg_s;
    logic              stable;
    logic              classify;
    logic              one_low;
    logic [DIGITS-1:0] cap;
    seg_dec_t          dec;

    assign an_low = ~sync2_q[SW-1:8];
    assign seg_s  = sync2_q[7:0];
    assign stable = (sync2_q == prev_q);

    seg_to_bcd u_dec (
        .seg_n (seg_s[6:0]),
        .dec   (dec)
    );

    // Synchronizer chain and stability counter
    always_comb begin
        sync1_d = {bus.an, bus.seg};
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cnt_d   = cnt_q;
        if (!stable)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    // Classify a sample once, when it has been stable long enough
    always_comb begin
        state_d  = state_q;
        classify = 1'b0;
        case (state_q)
            WAIT: begin
                if (stable && cnt_q == CNT_MAX) begin
                    classify = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!stable)
                    state_d = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        one_low    = $onehot(an_low);
        cap        = (classify && one_low) ? an_low : '0;
        scan_err_d = classify && !one_low && (an_low != '0);

        // A capture on the completion edge lands after the clear
        frame_valid_d = &seen_q;
        seen_d        = (frame_valid_d ? '0 : seen_q) | cap;

        digits_d  = digits_q;
        dp_d      = dp_q;
        blank_d   = blank_q;
        invalid_d = invalid_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (cap[i]) begin
                digits_d[i]  = dec.value;
                dp_d[i]      = ~seg_s[7];
                blank_d[i]   = dec.blank;
                invalid_d[i] = dec.invalid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '1;
            cnt_q         <= '0;
            state_q       <= WAIT;
            digits_q      <= {DIGITS{BLANK_CODE}};
            dp_q          <= '0;
            blank_q       <= '1;
            invalid_q     <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            scan_err_q    <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            blank_q       <= blank_d;
            invalid_q     <= invalid_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            scan_err_q    <= scan_err_d;
        end
    end

    assign bus.digits_bcd  = digits_q;
    assign bus.dp_lit      = dp_q;
    assign bus.blank       = blank_q;
    assign bus.invalid     = invalid_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.scan_err    = scan_err_q;

endmodule
